// File: rtl/dmem_loader.sv
// Streams len words from an upstream valid/ready source into data memory, holding the processing unit in reset until loaded.
// Optional trailing checksum word is verified when LOADER_CKSUM_EN is defined.
module dmem_loader #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   load_len,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] wdata,
   output logic              pu_rst,
   output logic              done,
   output logic              cksum_err
);

`ifdef LOADER_CKSUM_EN
   typedef enum logic [1:0] {IDLE, LOAD, CKSUM, DONE} state_t;
   localparam state_t POST_LOAD = CKSUM;
`else
   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
   localparam state_t POST_LOAD = DONE;
`endif

   localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

   state_t          state, state_nxt;
   logic [ADDR_W:0] len, cnt, len_in;
   logic            go, xfer, last;

   always_comb begin
      len_in = (load_len > MAX_LEN) ? MAX_LEN : load_len;
      go     = start && ((state == IDLE) || (state == DONE));
`ifdef LOADER_CKSUM_EN
      in_ready = (state == LOAD) || (state == CKSUM);
`else
      in_ready = (state == LOAD);
`endif
      xfer = in_valid && in_ready;
      last = (cnt == (len - 1'b1));
      done = (state == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            // An empty load skips straight past the data phase.
            if (start) state_nxt = (len_in == '0) ? POST_LOAD : LOAD;
         end
         LOAD: begin
            if (xfer && last) state_nxt = POST_LOAD;
         end
`ifdef LOADER_CKSUM_EN
         CKSUM: begin
            if (xfer) state_nxt = DONE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len    <= '0;
         cnt    <= '0;
         we     <= 1'b0;
         waddr  <= '0;
         wdata  <= '0;
         pu_rst <= 1'b1;
      end else begin
         we     <= 1'b0;
         // Released one edge after DONE is reached; a restart from DONE re-asserts it.
         pu_rst <= (state != DONE) || start;
         if (go) begin
            len <= len_in;
            cnt <= '0;
         end else if ((state == LOAD) && xfer) begin
            we    <= 1'b1;
            waddr <= cnt[ADDR_W-1:0];
            wdata <= in_data;
            cnt   <= cnt + 1'b1;
         end
      end
   end

`ifdef LOADER_CKSUM_EN
   logic [DATA_W-1:0] sum;
   logic              err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum   <= '0;
         err_q <= 1'b0;
      end else if (go) begin
         sum   <= '0;
         err_q <= 1'b0;
      end else if ((state == LOAD) && xfer) begin
         sum <= sum + in_data;
      end else if ((state == CKSUM) && xfer) begin
         err_q <= (in_data != sum);
      end
   end

   assign cksum_err = err_q;
`else
   assign cksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_loader.sv
// Self-checking bench for dmem_loader: vector table, directed corner sequences and randomized loads
// checked against a word-list model (expected writes, handshake count, checksum).
module tb_dmem_loader;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 8;
`ifdef LOADER_CKSUM_EN
   localparam bit CKS = 1'b1;
`else
   localparam bit CKS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, start, in_valid;
   logic [AW:0]   load_len;
   logic [DW-1:0] in_data;
   logic          in_ready, we, pu_rst, done, cksum_err;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;

   always #5 clk = ~clk;

   dmem_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .load_len(load_len),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .we(we), .waddr(waddr), .wdata(wdata), .pu_rst(pu_rst),
      .done(done), .cksum_err(cksum_err)
   );

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int unsigned   c;
   } wr_t;

   typedef struct {
      int unsigned len;
      int          mode;    // 0 always valid, 1 alternating, 2 random (with stray starts)
      int          wsel;    // 0 words 1..n, 1 random, 2 preset by caller
      bit          bad;     // corrupt trailing checksum word
      int unsigned exp_wr;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   int unsigned t = 0;
   wr_t         got[$];
   int unsigned hs[$];
   logic [DW-1:0] words [0:511];
   vec_t        tbl [7];

   task automatic chk(input string name, input logic [63:0] g, input logic [63:0] e);
      checks++;
      if (g !== e) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, g, e, $time);
      end
   endtask

   // Drive one cycle, then log the handshake and any write seen after the edge.
   task automatic tick(input logic s, input logic v, input logic [DW-1:0] d);
      logic rdy;
      start    = s;
      in_valid = v;
      in_data  = d;
      rdy      = in_ready;
      @(posedge clk);
      #1;
      t++;
      if (v && rdy) hs.push_back(t);
      if (we) got.push_back('{waddr, wdata, t});
      start    = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_we"}, we, 0);
      chk({tag, "_waddr"}, waddr, 0);
      chk({tag, "_wdata"}, wdata, 0);
      chk({tag, "_pu_rst"}, pu_rst, 1);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_cksum_err"}, cksum_err, 0);
   endtask

   task automatic pulse_reset(input string tag);
      rst = 1'b1;
      #1;
      check_reset_vals(tag);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic run_load(input int unsigned len, input int mode, input int wsel,
                           input bit bad, input int unsigned exp_wr, input string tag);
      int unsigned   n, ntot, k, budget;
      logic [DW-1:0] sum;
      bit            v, s, exp_err;
      n    = (len > 256) ? 256 : len;
      ntot = n + (CKS ? 1 : 0);
      for (int i = 0; i < int'(n); i++) begin
         if (wsel == 0)      words[i] = DW'(i + 1);
         else if (wsel == 1) words[i] = $urandom;
      end
      sum = '0;
      for (int i = 0; i < int'(n); i++) sum = sum + words[i];
      if (CKS && wsel != 2) words[n] = bad ? sum + 1 : sum;
      exp_err = CKS && (words[n] != sum);

      got.delete();
      hs.delete();
      load_len = (AW+1)'(len);
      tick(1'b1, 1'b0, $urandom);
      chk({tag, "_pu_rst_start"}, pu_rst, 1);
      chk({tag, "_err_clr"}, cksum_err, 0);
      chk({tag, "_done_start"}, done, (n == 0 && !CKS));

      k = 0;
      budget = 4 * ntot + 20;
      while (!done && budget > 0) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = (k % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         s = (mode == 2) && (hs.size() < ntot) && ($urandom_range(0, 3) == 0);
         tick(s, v, v ? words[hs.size()] : $urandom);
         k++;
         budget--;
      end
      chk({tag, "_done_reached"}, done, 1);
      chk({tag, "_pu_rst_first_done"}, pu_rst, 1);
      tick(1'b0, 1'b1, $urandom);
      chk({tag, "_pu_rst_released"}, pu_rst, 0);
      chk({tag, "_done_hold"}, done, 1);
      tick(1'b0, 1'b1, $urandom);

      chk({tag, "_nwrites"}, got.size(), exp_wr);
      chk({tag, "_nhandshakes"}, hs.size(), ntot);
      for (int i = 0; i < got.size() && i < int'(n); i++) begin
         chk($sformatf("%s_addr%0d", tag, i), got[i].a, i);
         chk($sformatf("%s_data%0d", tag, i), got[i].d, words[i]);
         if (i < hs.size())
            chk($sformatf("%s_lat%0d", tag, i), got[i].c, hs[i]);
      end
      if (got.size() > 0) chk({tag, "_last_addr"}, got[got.size()-1].a, n - 1);
      chk({tag, "_cksum_err"}, cksum_err, exp_err);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; load_len = '0; in_data = '0;
      tbl[0] = '{4,   0, 0, 1'b0, 4};
      tbl[1] = '{3,   1, 1, 1'b0, 3};
      tbl[2] = '{300, 0, 1, 1'b0, 256};
      tbl[3] = '{0,   0, 0, 1'b0, 0};
      tbl[4] = '{1,   2, 1, 1'b1, 1};
      tbl[5] = '{257, 2, 1, 1'b0, 256};
      tbl[6] = '{511, 1, 1, 1'b1, 256};

      #2;
      check_reset_vals("por");
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick(1'b0, 1'b1, 32'h55);
      chk("idle_no_write", got.size(), 0);
      chk("idle_no_ready", in_ready, 0);

      for (int i = 0; i < 7; i++)
         run_load(tbl[i].len, tbl[i].mode, tbl[i].wsel, tbl[i].bad, tbl[i].exp_wr,
                  $sformatf("vec%0d", i));

      words[0] = 5; words[1] = 7; words[2] = 12;
      run_load(2, 0, 2, 1'b0, 2, "cks12");
      chk("cks12_err", cksum_err, 0);
      words[2] = 13;
      run_load(2, 0, 2, 1'b0, 2, "cks13");
      chk("cks13_err", cksum_err, CKS);
      pulse_reset("rst_after_cks");

      load_len = 8;
      tick(1'b1, 1'b0, '0);
      tick(1'b0, 1'b1, 32'h11);
      tick(1'b0, 1'b1, 32'h22);
      chk("midload_we_before_rst", we, 1);
      pulse_reset("rst_midload");
      run_load(2, 0, 0, 1'b0, 2, "after_rst");

      for (int i = 0; i < 6; i++) begin
         int unsigned l;
         l = $urandom_range(0, 40);
         run_load(l, 2, 1, 1'($urandom_range(0, 1)), l, $sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
